// File: rtl/hub75_fb_arbiter.sv
// Shares one single-port frame-buffer RAM between the HUB75 read-out engine and a host port.
// Read-out bursts get exclusive ownership; the host is served in IDLE and in a bounded window after each burst.
module hub75_fb_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int HOST_SLOTS = 4,
  parameter int RO_TIMEOUT = 300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ro_pending,
  output logic              ro_boot,
  output logic              ro_active,
  input  logic              ro_done,
  input  logic [ADDR_W-1:0] ro_addr,
  output logic [15:0]       ro_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_write,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [15:0]       host_wdata,
  input  logic [3:0]        host_mask,
  output logic              host_rvalid,
  output logic [15:0]       host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [3:0]        mem_mask,
  output logic              mem_we,
  input  logic [15:0]       mem_rdata,
  output logic              err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RO_BOOT,
    S_RO_RUN,
    S_HOST_WIN
  } state_t;

  localparam logic [3:0] SLOTS   = 4'(HOST_SLOTS);
  localparam logic [9:0] WD_LAST = 10'(RO_TIMEOUT - 1);

  state_t     state;
  logic [3:0] slot_cnt;
  logic [9:0] wd_cnt;
  logic       host_fire;

  // Read data is shared: the read-out sees every RAM word, the host qualifies with host_rvalid.
  assign ro_data    = mem_rdata;
  assign host_rdata = mem_rdata;
  assign host_fire  = host_valid && host_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    host_ready = 1'b0;
    case (state)
      S_IDLE:     host_ready = host_valid && !ro_pending;
      S_HOST_WIN: host_ready = host_valid && (slot_cnt != 4'd0);
      default:    host_ready = 1'b0;
    endcase
    if (rst) host_ready = 1'b0;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mask  = '0;
    mem_we    = 1'b0;
    if (state == S_RO_RUN) begin
      mem_addr = ro_addr;
    end else if (host_fire) begin
      mem_addr = host_addr;
      if (host_write) begin
        mem_we    = 1'b1;
        mem_wdata = host_wdata;
        mem_mask  = host_mask;
      end
    end
  end

  // NOTE: all state and registered outputs update with non-blocking assignments in one clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      slot_cnt    <= '0;
      wd_cnt      <= '0;
      ro_boot     <= 1'b0;
      ro_active   <= 1'b0;
      host_rvalid <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      host_rvalid <= host_fire && !host_write;
      case (state)
        S_IDLE: begin
          if (ro_pending) begin
            state   <= S_RO_BOOT;
            ro_boot <= 1'b1;
          end
        end
        S_RO_BOOT: begin
          state     <= S_RO_RUN;
          ro_boot   <= 1'b0;
          ro_active <= 1'b1;
          wd_cnt    <= '0;
        end
        S_RO_RUN: begin
          wd_cnt <= wd_cnt + 10'd1;
          if (ro_done) begin
            state     <= S_HOST_WIN;
            ro_active <= 1'b0;
            slot_cnt  <= SLOTS;
          end else if (wd_cnt == WD_LAST) begin
            // Runaway burst: reclaim the RAM for the host and leave a sticky flag.
            state       <= S_HOST_WIN;
            ro_active   <= 1'b0;
            slot_cnt    <= SLOTS;
            err_timeout <= 1'b1;
          end
        end
        S_HOST_WIN: begin
          if (!host_valid || slot_cnt == 4'd0) state <= S_IDLE;
          else slot_cnt <= slot_cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
